// File: rtl/surface_gen_p_pkg.sv
// Shared types and constants for the parametrised surface generator.
// Holds the FSM state type, LFSR seed/taps and default reset patterns.
package surface_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GAP    = 2'd1,
      SETTLE = 2'd2
   } state_t;

   localparam logic [7:0] LFSR_SEED      = 8'hA5;
   // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
   localparam logic [7:0] LFSR_TAPS      = 8'b1011_1000;

   localparam logic       FLOOR_RST_FILL = 1'b1;
   localparam logic [5:0] CEIL_RST_DEF   = 6'b001100;

endpackage

// File: rtl/surface_gen_p_if.sv
// Scroll/transition request bus and surface outputs of the generator.
interface surface_gen_p_if #(
   parameter int W      = 6,
   parameter int DIFF_W = 4
);
   logic              MoveTick;
   logic              TransitionReq;
   logic [DIFF_W-1:0] TransitionDiff;
   logic [W-1:0]      Floor;
   logic [W-1:0]      Ceiling;
   logic              Side;
   logic              Busy;
   logic              Overrun;

   modport master (
      output MoveTick, TransitionReq, TransitionDiff,
      input  Floor, Ceiling, Side, Busy, Overrun
   );

   modport slave (
      input  MoveTick, TransitionReq, TransitionDiff,
      output Floor, Ceiling, Side, Busy, Overrun
   );
endinterface

// File: rtl/surface_gen_p_shift_reg.sv
// W-bit surface column shift register: serial in at bit 0, loadable reset value.
module surface_shift_reg #(
   parameter int           W       = 6,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         en,
   input  logic         sin,
   output logic [W-1:0] q
);

   always_ff @(posedge Clk) begin
      if (!Rst)
         q <= RST_VAL;
      else if (en)
         q <= {q[W-2:0], sin};
   end

endmodule

// File: rtl/surface_gen_p.sv
// Floor/ceiling column generator with bridge insertion, one-deep request buffer and overrun flag.
// Optional free-running auto transitions are enabled by SURFACE_AUTO_TRANSITION_EN.
//
// state  | meaning
// IDLE   | scrolling the active side pattern, waiting for a request
// GAP    | inserting bridge columns (both surfaces solid)
// SETTLE | side already swapped; next tick inserts one new-side column
module surface_gen_p
   import surface_pkg::*;
#(
   parameter int           W         = 6,
   parameter int           DIFF_W    = 4,
   parameter logic [W-1:0] FLOOR_RST = {W{FLOOR_RST_FILL}},
   parameter logic [W-1:0] CEIL_RST  = W'(CEIL_RST_DEF)
) (
   input logic           Clk,
   input logic           Rst,
   surface_gen_p_if.slave bus
);

   state_t            state;
   logic              side, pending, busy, overrun;
   logic [DIFF_W-1:0] pend_diff, cur_diff, count;

   logic              auto_req;
   logic [DIFF_W-1:0] auto_diff;
   logic              idle_tick, start, req_buffer, bridge, fin, cin;
   logic              pending_n, active_n;
   logic [DIFF_W-1:0] start_diff;

   function automatic logic [DIFF_W-1:0] deff(input logic [DIFF_W-1:0] d);
      return (d == '0) ? DIFF_W'(1) : d;
   endfunction

`ifdef SURFACE_AUTO_TRANSITION_EN
   logic [7:0] lfsr;

   always_ff @(posedge Clk) begin
      if (!Rst)
         lfsr <= LFSR_SEED;
      else if (bus.MoveTick)
         lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
   end

   assign auto_req  = (lfsr[2:0] == 3'd0);
   assign auto_diff = lfsr[3 +: DIFF_W];
`else
   assign auto_req  = 1'b0;
   assign auto_diff = '0;
`endif

   always_comb begin
      idle_tick  = (state == IDLE) && bus.MoveTick;
      start      = idle_tick && (pending || bus.TransitionReq || auto_req);
      req_buffer = bus.TransitionReq && !idle_tick;
      start_diff = pending ? pend_diff : (bus.TransitionReq ? bus.TransitionDiff : auto_diff);
      bridge     = (idle_tick && start) || (state == GAP);
      // In SETTLE the side has already flipped, so the plain side pattern is the new side
      fin        = bridge || !side;
      cin        = bridge || side;
      pending_n  = req_buffer ? 1'b1 : (start ? 1'b0 : pending);
      active_n   = (state != IDLE);
      if (bus.MoveTick) begin
         unique case (state)
            IDLE:    active_n = start;
            GAP:     active_n = 1'b1;
            SETTLE:  active_n = 1'b0;
            default: active_n = 1'b0;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state     <= IDLE;
         side      <= 1'b0;
         pending   <= 1'b0;
         pend_diff <= '0;
         cur_diff  <= '0;
         count     <= '0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (req_buffer) begin
            if (pending)
               overrun <= 1'b1;
            else begin
               pending   <= 1'b1;
               pend_diff <= bus.TransitionDiff;
            end
         end else if (start) begin
            pending <= 1'b0;
         end

         if (bus.MoveTick) begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     count    <= DIFF_W'(1);
                     cur_diff <= start_diff;
                     if (deff(start_diff) == DIFF_W'(1)) begin
                        side  <= ~side;
                        state <= SETTLE;
                     end else begin
                        state <= GAP;
                     end
                  end
               end
               GAP: begin
                  count <= DIFF_W'(count + 1'b1);
                  if (DIFF_W'(count + 1'b1) == deff(cur_diff)) begin
                     side  <= ~side;
                     state <= SETTLE;
                  end
               end
               SETTLE:  state <= IDLE;
               default: state <= IDLE;
            endcase
         end

         busy <= active_n || pending_n;
      end
   end

   surface_shift_reg #(.W(W), .RST_VAL(FLOOR_RST)) u_floor (
      .Clk (Clk),
      .Rst (Rst),
      .en  (bus.MoveTick),
      .sin (fin),
      .q   (bus.Floor)
   );

   surface_shift_reg #(.W(W), .RST_VAL(CEIL_RST)) u_ceil (
      .Clk (Clk),
      .Rst (Rst),
      .en  (bus.MoveTick),
      .sin (cin),
      .q   (bus.Ceiling)
   );

   assign bus.Side    = side;
   assign bus.Busy    = busy;
   assign bus.Overrun = overrun;

endmodule

// File: tb/tb_surface_gen_p.sv
// Directed + randomized bench for surface_gen_p against a queue-based column schedule model.
module tb_surface_gen_p;

   localparam int W      = 6;
   localparam int DIFF_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   surface_gen_p_if #(.W(W), .DIFF_W(DIFF_W)) bus ();

   surface_gen_p #(.W(W), .DIFF_W(DIFF_W)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit f;
      bit c;
      bit flip;
   } col_t;

   col_t         sched[$];
   logic [W-1:0] m_floor, m_ceil;
   bit           m_side, m_pend, m_ovr;
   int           m_pdiff;
   bit [7:0]     m_lfsr;
   int           m_flips;

   task automatic model_step(input bit r, input bit t, input bit q, input int d);
      bit   idle_tick, auto_hit, start;
      int   len;
      col_t col;
      if (!r) begin
         m_floor = '1;
         m_ceil  = W'(6'b001100);
         m_side  = 0;
         m_pend  = 0;
         m_ovr   = 0;
         m_lfsr  = 8'hA5;
         sched.delete();
         return;
      end
      m_ovr     = 0;
      idle_tick = t && (sched.size() == 0);
      auto_hit  = 0;
`ifdef SURFACE_AUTO_TRANSITION_EN
      auto_hit  = (m_lfsr % 8) == 0;
`endif
      start = 0;
      len   = 0;
      if (idle_tick) begin
         if (m_pend) begin
            start = 1; len = m_pdiff; m_pend = 0;
         end else if (q) begin
            start = 1; len = d;
         end else if (auto_hit) begin
            start = 1; len = (m_lfsr >> 3) % (1 << DIFF_W);
         end
      end
      if (start) begin
         if (len == 0) len = 1;
         for (int i = 0; i < len; i++) sched.push_back('{1'b1, 1'b1, i == len - 1});
         // settle column carries the pattern of the side we are switching to
         sched.push_back('{m_side, !m_side, 1'b0});
      end
      if (t) begin
         if (sched.size() != 0) col = sched.pop_front();
         else                   col = '{!m_side, m_side, 1'b0};
         m_floor = {m_floor[W-2:0], col.f};
         m_ceil  = {m_ceil[W-2:0], col.c};
         if (col.flip) begin
            m_side = !m_side;
            m_flips++;
         end
         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
      if (q && !idle_tick) begin
         if (m_pend) m_ovr = 1;
         else begin
            m_pend  = 1;
            m_pdiff = d;
         end
      end
   endtask

   task automatic check_all(input string tag);
      bit m_busy;
      m_busy = (sched.size() != 0) || m_pend;
      checks++;
      assert (bus.Floor === m_floor) else begin
         failures++;
         $error("FAIL %s floor got=%b exp=%b", tag, bus.Floor, m_floor);
      end
      checks++;
      assert (bus.Ceiling === m_ceil) else begin
         failures++;
         $error("FAIL %s ceiling got=%b exp=%b", tag, bus.Ceiling, m_ceil);
      end
      checks++;
      assert (bus.Side === m_side) else begin
         failures++;
         $error("FAIL %s side got=%b exp=%b", tag, bus.Side, m_side);
      end
      checks++;
      assert (bus.Busy === m_busy) else begin
         failures++;
         $error("FAIL %s busy got=%b exp=%b", tag, bus.Busy, m_busy);
      end
      checks++;
      assert (bus.Overrun === m_ovr) else begin
         failures++;
         $error("FAIL %s overrun got=%b exp=%b", tag, bus.Overrun, m_ovr);
      end
   endtask

   task automatic step(input string tag, input bit r, input bit t, input bit q, input int d);
      rst                = r;
      bus.MoveTick       = t;
      bus.TransitionReq  = q;
      bus.TransitionDiff = d[DIFF_W-1:0];
      @(posedge clk);
      model_step(r, t, q, d);
      #1;
      check_all(tag);
      rst               = 1'b1;
      bus.MoveTick      = 1'b0;
      bus.TransitionReq = 1'b0;
   endtask

   initial begin
      logic [W-1:0] ceil_exp[5];
      int           dut_flips;
      bit           prev_side;

      ceil_exp[0] = 6'b011000;
      ceil_exp[1] = 6'b110000;
      ceil_exp[2] = 6'b100000;
      ceil_exp[3] = 6'b000000;
      ceil_exp[4] = 6'b000000;

      bus.MoveTick       = 1'b0;
      bus.TransitionReq  = 1'b0;
      bus.TransitionDiff = '0;
      m_flips            = 0;

      step("reset", 0, 1, 1, 5);
      step("reset2", 0, 0, 0, 0);

      for (int i = 0; i < 5; i++) begin
         step("idle", 1, 1, 0, 0);
         checks++;
         assert (bus.Ceiling === ceil_exp[i] && bus.Floor === 6'b111111) else begin
            failures++;
            $error("FAIL idle_seq ceil=%b floor=%b exp_ceil=%b", bus.Ceiling, bus.Floor, ceil_exp[i]);
         end
      end

      step("req3", 1, 0, 1, 3);
      for (int i = 0; i < 5; i++) step("diff3", 1, 1, 0, 0);
      checks++;
      assert (bus.Ceiling[4:0] === 5'b11111 && bus.Floor[4:0] === 5'b11100) else begin
         failures++;
         $error("FAIL diff3_cols floor=%b ceil=%b", bus.Floor, bus.Ceiling);
      end

      step("req0", 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) step("diff0", 1, 1, 0, 0);

      step("gap_req", 1, 1, 1, 4);
      step("gap_tick", 1, 1, 0, 0);
      step("buf_req", 1, 0, 1, 2);
      step("ovr_req", 1, 0, 1, 9);
      step("after_ovr", 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step("drain", 1, 1, 0, 0);

      step("rst_req", 1, 1, 1, 5);
      step("rst_gap", 1, 1, 0, 0);
      step("rst_mid", 0, 1, 1, 2);
      step("post_rst", 1, 0, 0, 0);

      dut_flips = 0;
      m_flips   = 0;
      prev_side = bus.Side;
      for (int i = 0; i < 64; i++) begin
         step("free64", 1, 1, 0, 0);
         if (bus.Side !== prev_side) dut_flips++;
         prev_side = bus.Side;
      end
      checks++;
      assert (dut_flips === m_flips) else begin
         failures++;
         $error("FAIL free64_flips got=%0d exp=%0d", dut_flips, m_flips);
      end
`ifndef SURFACE_AUTO_TRANSITION_EN
      checks++;
      assert (dut_flips === 0) else begin
         failures++;
         $error("FAIL no_auto got=%0d exp=0", dut_flips);
      end
`endif

      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom % 60) != 0, $urandom % 2, ($urandom % 4) == 0, $urandom % 16);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
